// File: rtl/debug_ctrl.sv
// UART debug controller: loads instruction memory, runs or single-steps the datapath, dumps PC/RB/DM MSB first.
// Each sent byte waits for i_tx_done; defining DEBUG_CTRL_CHECKSUM_EN appends an XOR byte to every dump region.
module debug_ctrl #(
    parameter int NB_WORD  = 32,
    parameter int IM_DEPTH = 256,
    parameter int RB_DEPTH = 32,
    parameter int DM_DEPTH = 128
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_rx_done,
    input  logic [7:0]                  i_rx_data,
    input  logic                        i_tx_done,
    output logic                        o_tx_start,
    output logic [7:0]                  o_tx_data,
    input  logic                        i_hlt,
    input  logic [NB_WORD-1:0]          i_pc_value,
    input  logic [NB_WORD-1:0]          i_rb_data,
    input  logic [NB_WORD-1:0]          i_dm_data,
    output logic [$clog2(IM_DEPTH)-1:0] o_im_addr,
    output logic [7:0]                  o_im_data,
    output logic                        o_im_write_enable,
    output logic [$clog2(RB_DEPTH)-1:0] o_rb_addr,
    output logic [$clog2(DM_DEPTH)-1:0] o_dm_addr,
    output logic                        o_rb_read_enable,
    output logic                        o_dm_read_enable,
    output logic                        o_dp_enable,
    output logic                        o_step,
    output logic [3:0]                  o_state
);
    localparam int IM_AW  = $clog2(IM_DEPTH);
    localparam int RB_AW  = $clog2(RB_DEPTH);
    localparam int DM_AW  = $clog2(DM_DEPTH);
    localparam int NBYTES = NB_WORD / 8;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_LOAD_LEN = 4'd1, S_LOAD_DATA = 4'd2, S_READY = 4'd3, S_RUN = 4'd4,
        S_STEP = 4'd5, S_DUMP_PC = 4'd6, S_DUMP_RB = 4'd7, S_DUMP_DM = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        PH_RD, PH_LOAD, PH_TX, PH_END, PH_CK, PH_DONE
    } phase_t;

    state_t             state_q;
    phase_t             ph_q;
    logic               tx_start_q, im_we_q, rb_re_q, dm_re_q, dp_en_q, step_q;
    logic [7:0]         tx_data_q, im_data_q, bcnt_q;
    logic [IM_AW-1:0]   im_addr_q;
    logic [RB_AW-1:0]   rb_addr_q;
    logic [DM_AW-1:0]   dm_addr_q;
    logic [15:0]        len_q, idx_q;
    logic               len_hi_q, auto_q, step_mode_q, halted_q;
    logic [NB_WORD-1:0] shift_q, load_word;
    logic               rx_vld, tx_ack;
`ifdef DEBUG_CTRL_CHECKSUM_EN
    logic [7:0]         xor_q;
    logic               dumping;
    assign dumping = (state_q == S_DUMP_PC) || (state_q == S_DUMP_RB) || (state_q == S_DUMP_DM);
`endif

    // A received byte colliding with a transmit completion is dropped.
    assign rx_vld = i_rx_done & ~i_tx_done;
    assign tx_ack = i_tx_done & ~tx_start_q;

    always_comb begin
        load_word = i_dm_data;
        if (state_q == S_DUMP_PC)      load_word = i_pc_value;
        else if (state_q == S_DUMP_RB) load_word = i_rb_data;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;      ph_q <= PH_RD;
            tx_start_q <= 1'b0;     tx_data_q <= '0;
            im_we_q <= 1'b0;        im_addr_q <= '0;     im_data_q <= '0;
            rb_re_q <= 1'b0;        dm_re_q <= 1'b0;
            rb_addr_q <= '0;        dm_addr_q <= '0;
            dp_en_q <= 1'b0;        step_q <= 1'b0;
            len_q <= '0;            idx_q <= '0;         len_hi_q <= 1'b0;
            shift_q <= '0;          bcnt_q <= '0;
            auto_q <= 1'b0;         step_mode_q <= 1'b0; halted_q <= 1'b0;
`ifdef DEBUG_CTRL_CHECKSUM_EN
            xor_q <= '0;
`endif
        end else begin
            im_we_q    <= 1'b0;
            tx_start_q <= 1'b0;
            rb_re_q    <= 1'b0;
            dm_re_q    <= 1'b0;
            step_q     <= 1'b0;
`ifdef DEBUG_CTRL_CHECKSUM_EN
            if (!dumping || ph_q == PH_DONE) xor_q <= '0;
`endif
            case (state_q)
                S_IDLE: begin
                    auto_q <= 1'b0; step_mode_q <= 1'b0; halted_q <= 1'b0; dp_en_q <= 1'b0;
                    if (rx_vld) begin
                        case (i_rx_data)
                            8'h01: begin state_q <= S_LOAD_LEN; len_hi_q <= 1'b0; end
                            8'h04: begin state_q <= S_DUMP_RB; rb_addr_q <= '0; rb_re_q <= 1'b1; ph_q <= PH_RD; end
                            8'h05: begin state_q <= S_DUMP_DM; dm_addr_q <= '0; dm_re_q <= 1'b1; ph_q <= PH_RD; end
                            8'h06: begin state_q <= S_DUMP_PC; ph_q <= PH_LOAD; end
                            default: ;
                        endcase
                    end
                end
                S_LOAD_LEN: if (rx_vld) begin
                    if (!len_hi_q) begin
                        len_q[15:8] <= i_rx_data;
                        len_hi_q    <= 1'b1;
                    end else begin
                        len_q[7:0] <= i_rx_data;
                        idx_q      <= '0;
                        state_q    <= ({len_q[15:8], i_rx_data} == 16'd0) ? S_IDLE : S_LOAD_DATA;
                    end
                end
                S_LOAD_DATA: if (rx_vld) begin
                    // Bytes beyond the instruction memory are consumed but not written.
                    if (int'(idx_q) < IM_DEPTH) begin
                        im_we_q   <= 1'b1;
                        im_addr_q <= idx_q[IM_AW-1:0];
                        im_data_q <= i_rx_data;
                    end
                    idx_q <= idx_q + 16'd1;
                    if (idx_q == len_q - 16'd1) state_q <= S_READY;
                end
                S_READY: if (rx_vld) begin
                    if (i_rx_data == 8'h02) begin
                        state_q <= S_RUN; dp_en_q <= 1'b1; step_mode_q <= 1'b0;
                    end else if (i_rx_data == 8'h03) begin
                        state_q <= S_STEP; step_mode_q <= 1'b1;
                    end
                end
                S_RUN: if (i_hlt) begin
                    dp_en_q <= 1'b0; halted_q <= 1'b1; auto_q <= 1'b1;
                    state_q <= S_DUMP_PC; ph_q <= PH_LOAD;
                end
                S_STEP: begin
                    if (step_q) begin
                        dp_en_q <= 1'b0; halted_q <= i_hlt; auto_q <= 1'b1;
                        state_q <= S_DUMP_PC; ph_q <= PH_LOAD;
                    end else if (rx_vld && i_rx_data == 8'h07) begin
                        step_q <= 1'b1; dp_en_q <= 1'b1;
                    end else if (rx_vld && i_rx_data == 8'h08) begin
                        state_q <= S_RUN; dp_en_q <= 1'b1; step_mode_q <= 1'b0;
                    end
                end
                default: begin
                    case (ph_q)
                        PH_RD: ph_q <= PH_LOAD;
                        PH_LOAD: begin
                            tx_start_q <= 1'b1;
                            tx_data_q  <= load_word[NB_WORD-1 -: 8];
                            shift_q    <= load_word << 8;
                            bcnt_q     <= 8'd1;
                            ph_q       <= PH_TX;
`ifdef DEBUG_CTRL_CHECKSUM_EN
                            xor_q <= xor_q ^ load_word[NB_WORD-1 -: 8];
`endif
                        end
                        PH_TX: if (tx_ack) begin
                            if (bcnt_q == 8'(NBYTES)) begin
                                if (state_q == S_DUMP_RB && rb_addr_q != RB_AW'(RB_DEPTH - 1)) begin
                                    rb_addr_q <= rb_addr_q + 1'b1; rb_re_q <= 1'b1; ph_q <= PH_RD;
                                end else if (state_q == S_DUMP_DM && dm_addr_q != DM_AW'(DM_DEPTH - 1)) begin
                                    dm_addr_q <= dm_addr_q + 1'b1; dm_re_q <= 1'b1; ph_q <= PH_RD;
                                end else begin
                                    ph_q <= PH_END;
                                end
                            end else begin
                                tx_start_q <= 1'b1;
                                tx_data_q  <= shift_q[NB_WORD-1 -: 8];
                                shift_q    <= shift_q << 8;
                                bcnt_q     <= bcnt_q + 8'd1;
`ifdef DEBUG_CTRL_CHECKSUM_EN
                                xor_q <= xor_q ^ shift_q[NB_WORD-1 -: 8];
`endif
                            end
                        end
`ifdef DEBUG_CTRL_CHECKSUM_EN
                        PH_END: begin tx_start_q <= 1'b1; tx_data_q <= xor_q; ph_q <= PH_CK; end
`else
                        PH_END: ph_q <= PH_DONE;
`endif
                        PH_CK: if (tx_ack) ph_q <= PH_DONE;
                        default: begin
                            // Region finished: chain the auto-dump or return.
                            case (state_q)
                                S_DUMP_PC: if (auto_q) begin
                                    state_q <= S_DUMP_RB; rb_addr_q <= '0; rb_re_q <= 1'b1; ph_q <= PH_RD;
                                end else state_q <= S_IDLE;
                                S_DUMP_RB: if (auto_q) begin
                                    state_q <= S_DUMP_DM; dm_addr_q <= '0; dm_re_q <= 1'b1; ph_q <= PH_RD;
                                end else state_q <= S_IDLE;
                                default: begin
                                    state_q <= (auto_q && step_mode_q && !halted_q) ? S_STEP : S_IDLE;
                                    auto_q  <= 1'b0;
                                end
                            endcase
                        end
                    endcase
                end
            endcase
        end
    end

    assign o_tx_start        = tx_start_q;
    assign o_tx_data         = tx_data_q;
    assign o_im_addr         = im_addr_q;
    assign o_im_data         = im_data_q;
    assign o_im_write_enable = im_we_q;
    assign o_rb_addr         = rb_addr_q;
    assign o_dm_addr         = dm_addr_q;
    assign o_rb_read_enable  = rb_re_q;
    assign o_dm_read_enable  = dm_re_q;
    assign o_dp_enable       = dp_en_q;
    assign o_step            = step_q;
    assign o_state           = state_q;
endmodule

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 SHALL have parameter NB_WORD, default 32: PC/register/data-memory word width, a multiple of 8.
REQ-002 SHALL have parameter IM_DEPTH, default 256: instruction memory size in bytes.
REQ-003 SHALL have parameter RB_DEPTH, default 32, and DM_DEPTH, default 128: register and data-memory word counts.
REQ-004 SHALL have i_clock  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have i_reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have i_rx_done  in  1, and i_rx_data  in  8: UART received byte, valid while i_rx_done is high.
REQ-007 SHALL have i_tx_done  in  1: UART byte sent; o_tx_start  out  1; o_tx_data  out  8.
REQ-008 SHALL have i_hlt  in  1: datapath executed HALT.
REQ-009 SHALL have i_pc_value, i_rb_data and i_dm_data  in  NB_WORD: PC value, register read data, data-memory read data.
REQ-010 SHALL have o_im_addr  out  clog2(IM_DEPTH); o_im_data  out  8; o_im_write_enable  out  1.
REQ-011 SHALL have o_rb_addr  out  clog2(RB_DEPTH); o_dm_addr  out  clog2(DM_DEPTH); o_rb_read_enable and o_dm_read_enable  out  1.
REQ-012 SHALL have o_dp_enable  out  1: datapath clock enable; o_step  out  1: single-cycle step pulse; o_state  out  4.

Function
REQ-013 SHALL decode these commands in IDLE: 0x01 LOAD, 0x02 RUN, 0x03 STEP_MODE, 0x04 DUMP_RB, 0x05 DUMP_DM, 0x06 DUMP_PC. Any other byte SHALL be ignored.
REQ-014 SHALL implement these states: IDLE, LOAD_LEN, LOAD_DATA, READY, RUN, STEP, DUMP_PC, DUMP_RB, DUMP_DM.
REQ-015 On LOAD, the next two bytes SHALL form a big-endian length L; state goes LOAD_LEN -> LOAD_DATA.
REQ-016 In LOAD_DATA, each received byte SHALL pulse o_im_write_enable for one cycle, with o_im_data equal to the byte and o_im_addr equal to the byte index (starting at 0).
REQ-017 When L=0, the block SHALL go to IDLE without writing; bytes with index >= IM_DEPTH SHALL be consumed but not written.
REQ-018 After the L-th byte, the block SHALL enter READY; READY SHALL accept 0x02 (-> RUN) or 0x03 (-> STEP) and ignore all other bytes.
REQ-019 In RUN, o_dp_enable SHALL be 1; when i_hlt=1, o_dp_enable SHALL drop on the next cycle and the block SHALL enter DUMP_PC.
REQ-020 In STEP, o_dp_enable SHALL be 0; 0x07 SHALL raise o_step and o_dp_enable for exactly one cycle, then go to DUMP_PC.
REQ-021 In STEP, 0x08 SHALL go to RUN; i_hlt during a step pulse SHALL still complete the dump, then go to IDLE.
REQ-022 Each dump word SHALL be sent as NB_WORD/8 bytes, MSB first.
REQ-023 Each byte SHALL be sent as a one-cycle o_tx_start pulse with o_tx_data held stable; the next byte SHALL NOT start until i_tx_done is seen.
REQ-024 Register and data-memory reads SHALL be 1-cycle synchronous: address and read_enable are presented, and data is sampled on the following cycle.
REQ-025 Auto-dump sequence after a step or halt SHALL be DUMP_PC -> DUMP_RB (all RB_DEPTH words) -> DUMP_DM (all DM_DEPTH words).
REQ-026 After the auto-dump, the block SHALL return to STEP in step mode without halt, otherwise to IDLE.
REQ-027 A single dump command issued from IDLE SHALL send only that region, then return to IDLE.
REQ-028 i_rx_done SHALL be ignored in RUN and in all DUMP_* states.
REQ-029 Address counters SHALL clear at the start of each dump and SHALL never wrap past DEPTH-1.
REQ-030 If i_tx_done and i_rx_done arrive in the same cycle, i_tx_done SHALL be processed and the received byte dropped.

Reset
REQ-031 i_reset SHALL return all state to IDLE on the next edge, including mid-load or mid-dump; partial transfers SHALL be abandoned.
REQ-032 After reset, all outputs SHALL be 0, counters 0, and o_state SHALL encode IDLE (4'd0).

Configuration
REQ-033 With DEBUG_CTRL_CHECKSUM_EN defined, each dump region SHALL be followed by one extra byte: the XOR of all bytes sent in that region, using the same handshake.
REQ-034 Without DEBUG_CTRL_CHECKSUM_EN, no checksum byte SHALL be sent and no checksum logic SHALL exist.

Verification
REQ-035 Bytes 0x01,0x00,0x03,0xAA,0xBB,0xCC -> three IM writes at addresses 0,1,2 with data AA,BB,CC, then o_state=READY.
REQ-036 Bytes 0x01,0x00,0x00 -> no IM write, block back in IDLE.
REQ-037 Byte 0x06 with i_pc_value=0x12345678, i_tx_done one cycle after each start -> bytes 12,34,56,78, then IDLE; with the checksum macro, a fifth byte 0x08.
REQ-038 READY, byte 0x03, byte 0x07 -> exactly one cycle of o_step=1, then 4+4*RB_DEPTH+4*DM_DEPTH bytes sent, then back in STEP.
REQ-039 RUN with i_hlt asserted at cycle 50 -> o_dp_enable=0 at cycle 51, full dump sent, then IDLE.
REQ-040 i_reset asserted after the 10th register byte -> o_tx_start=0 and state IDLE on the next edge; a following 0x04 restarts the dump at o_rb_addr=0.
